// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module bit_synchronizer #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= RESET_VALUE;
      q        <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with centre sampling and a one-entry valid/ready output register.
// Define UART_RECEIVER_PARITY_EN for 8E1 framing with parity checking.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] read_data,
  output logic                      read_valid,
  input  logic                      read_ready,
  output logic                      framing_error,
  output logic                      parity_error,
  output logic                      overrun_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  uart_state_t               state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [BIT_W-1:0]          bit_reg, bit_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic                      rx_sync;
  logic                      tick;
  logic                      stop_sample;
  logic                      par_bad;
  logic                      deliver;

  bit_synchronizer #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_sync)
  );

  assign tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (!rx_sync) state_next = START;
      START:     if (cnt_reg == CNT_HALF) state_next = rx_sync ? IDLE : DATA;
      DATA: begin
        if (tick && bit_reg == BIT_LAST) begin
`ifdef UART_RECEIVER_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RECEIVER_PARITY_EN
      PARITY:    if (tick) state_next = STOP;
`endif
      STOP:      if (tick) state_next = rx_sync ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next    = cnt_reg + 1'b1;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    stop_sample = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
      end
      START: if (cnt_reg == CNT_HALF) cnt_next = '0;
      DATA: begin
        if (tick) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift_reg[UART_DATA_BITS-1:1]};
          bit_next   = bit_reg + 1'b1;
        end
      end
      PARITY: if (tick) cnt_next = '0;
      STOP: begin
        if (tick) begin
          cnt_next    = '0;
          stop_sample = 1'b1;
        end
      end
      default: cnt_next = '0;
    endcase
  end

`ifdef UART_RECEIVER_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero; held until the stop sample.
  logic par_bad_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      par_bad_reg <= 1'b0;
    end else if (state_reg == PARITY && tick) begin
      par_bad_reg <= ^{shift_reg, rx_sync};
    end
  end

  assign par_bad = par_bad_reg;
`else
  assign par_bad = 1'b0;
`endif

  assign deliver = stop_sample && rx_sync && !par_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data     <= '0;
      read_valid    <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= stop_sample && !rx_sync;
      parity_error  <= stop_sample && par_bad;
      overrun_error <= deliver && read_valid && !read_ready;
      if (deliver) begin
        read_data  <= shift_reg;
        read_valid <= 1'b1;
      end else if (read_valid && read_ready) begin
        read_valid <= 1'b0;
      end
    end
  end

endmodule
